reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the multi-issue in-order pipeline. It replaces fixed single-issue stall logic with per-register latency countdowns.
- Tracks pending destination writes from NISSUE slots per cycle, each with its own result latency. Answers source-busy queries and grants in-order issue per slot.
- Sits in decode, beside the register file. Drives the fetch/decode stall and the execute-stage bubble insertion.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hardwired zero
AW, 5, register address width, equal to log2(NREGS)
NISSUE, 2, issue slots per cycle; slot 0 is oldest
NSRC, 2, source operands per slot
LATW, 3, latency field width; maximum latency is 2^LATW-1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  clears all pending entries; blocks all issue this cycle
issue_valid  input  NISSUE  slot i holds a decoded instruction
issue_wr  input  NISSUE  slot i writes a destination register
issue_dst  input  NISSUE*AW  destination of slot i, at bits [i*AW +: AW]
issue_lat  input  NISSUE*LATW  result latency of slot i in cycles; 0 is treated as 1
src_addr  input  NISSUE*NSRC*AW  source j of slot i, at index i*NSRC+j
src_busy  output  NISSUE*NSRC  combinational; source is pending
issue_ok  output  NISSUE  combinational; slot i issues this cycle
stall  output  1  combinational; some valid slot is not granted
busy_vec  output  NREGS  registered; bit r means cnt[r]!=0

Behaviour:
- State: one counter cnt[r] of LATW bits per register r. Reset: all cnt=0 and busy_vec=0. Reset overrides flush and issue.
- Effective latency Le = max(issue_lat,1). On accept, the target counter is loaded with Le-1.
- Le=1 gives full forwarding: the dependent instruction issues back-to-back. Le=L means the dependent instruction issues L cycles after the producer.
- Each edge, every nonzero cnt decrements by 1 and saturates at 0.
- WAW on issue: new cnt = max(cnt-1 saturated, Le-1). Two accepted slots in the same cycle with the same dst: take the max over both and the decremented old value.
- Writes with dst=0, or with issue_wr=0, never load a counter.
- src_busy[i,j]=1 when either condition holds:
  - src != 0 and cnt[src] != 0;
  - an earlier slot k<i in the same group has issue_valid and issue_wr, and its dst equals src != 0. This intra-group RAW is busy regardless of latency, since there is no same-cycle forwarding.
- issue_ok[i] = issue_valid[i] & ~flush & ~reset & no src_busy for slot i & (i==0 | issue_ok[i-1]). This enforces strict in-order issue: a blocked slot blocks all younger slots.
- stall = OR over i of (issue_valid[i] & ~issue_ok[i]).
- Only slots with issue_ok load counters.
- flush: all cnt cleared at the next edge. Issue is suppressed in the flush cycle. busy_vec is 0 in the following cycle.
- src_busy is computed from current cnt, not the next-cycle value. No combinational path exists from issue_* to busy_vec.
- The caller keeps issue_* stable while stall=1. The block holds no per-instruction state.

Test Plan:
- Reset, then idle: busy_vec=0, issue_ok=11 for two independent valid slots, stall=0.
- Slot0 writes r5 with lat=3 in cycle 0; slot0 reads r5 in cycles 1..3 -> src_busy=1 and stall=1 in cycles 1 and 2; issue_ok[0]=1 in cycle 3; busy_vec[5] high in cycles 1-2 only.
- Same cycle: slot0 writes r7 (lat 1), slot1 reads r7 -> issue_ok=01, stall=1. Next cycle, with slot1's instruction re-presented as slot0, it issues.
- WAW: r4 lat 7 in cycle 0, then r4 lat 2 in cycle 1 -> cnt stays on the lat-7 countdown; r4 free in cycle 7, not in cycle 3.
- Slot0 blocked on r9 while slot1 is independent -> issue_ok=00, and slot1 loads no counter.
- Flush with r3 (lat 6) pending and a valid issue in the same cycle -> issue_ok=00; busy_vec=0 next cycle. dst=0 with lat 7 -> busy_vec stays 0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for a multi-issue in-order pipeline.
// Each architectural register has a latency countdown. Each source operand is
// reported busy while its producer's result is still in flight, or when an
// older slot in the same issue group writes it. Slots are granted strictly in
// order, so a blocked slot also blocks every younger slot.
module reg_scoreboard #(
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NISSUE = 2,
  parameter int NSRC   = 2,
  parameter int LATW   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NISSUE-1:0]           issue_valid,
  input  logic [NISSUE-1:0]           issue_wr,
  input  logic [NISSUE*AW-1:0]        issue_dst,
  input  logic [NISSUE*LATW-1:0]      issue_lat,
  input  logic [NISSUE*NSRC*AW-1:0]   src_addr,
  output logic [NISSUE*NSRC-1:0]      src_busy,
  output logic [NISSUE-1:0]           issue_ok,
  output logic                        stall,
  output logic [NREGS-1:0]            busy_vec
);

  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];
  logic [NREGS-1:0] busy_vec_q;
  logic [NREGS-1:0] busy_vec_d;

  // Source-busy: a pending countdown, or an older same-group slot writing it.
  always_comb begin
    logic [AW-1:0] s;
    logic          b;
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    src_busy = '0;
    s        = '0;
    b        = 1'b0;
    for (int i = 0; i < NISSUE; i++) begin
      for (int j = 0; j < NSRC; j++) begin
        s = src_addr[(i*NSRC+j)*AW +: AW];
        b = (s != '0) && (cnt_q[s] != '0);
        for (int k = 0; k < i; k++) begin
          if (issue_valid[k] && issue_wr[k] &&
              (issue_dst[k*AW +: AW] == s) && (s != '0))
            b = 1'b1;
        end
        src_busy[i*NSRC+j] = b;
      end
    end
  end

  // In-order grant chain: a slot issues only if every older slot issued.
  always_comb begin
    logic older_ok;
    issue_ok = '0;
    stall    = 1'b0;
    older_ok = 1'b1;
    for (int i = 0; i < NISSUE; i++) begin
      issue_ok[i] = issue_valid[i] && !flush && !reset &&
                    !(|src_busy[i*NSRC +: NSRC]) && older_ok;
      older_ok    = issue_ok[i];
      if (issue_valid[i] && !issue_ok[i])
        stall = 1'b1;
    end
  end

  // Next countdowns: decrement, then raise to Le-1 for each granted write.
  always_comb begin
    logic [AW-1:0]   d;
    logic [LATW-1:0] l;
    logic [LATW-1:0] le_m1;
    d     = '0;
    l     = '0;
    le_m1 = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : '0;
    for (int i = 0; i < NISSUE; i++) begin
      d     = issue_dst[i*AW +: AW];
      l     = issue_lat[i*LATW +: LATW];
      // A latency of 0 behaves like 1: full forwarding, counter stays at 0.
      le_m1 = (l == '0) ? '0 : l - LATW'(1);
      // Taking the max covers WAW against older writes and same-group writes.
      if (issue_ok[i] && issue_wr[i] && (d != '0) && (le_m1 > cnt_d[d]))
        cnt_d[d] = le_m1;
    end
    if (flush) begin
      for (int r = 0; r < NREGS; r++)
        cnt_d[r] = '0;
    end
    for (int r = 0; r < NREGS; r++)
      busy_vec_d[r] = (cnt_d[r] != '0);
  end

  // State register with synchronous reset; the counter array must be reset
  // because its contents decide hazards from the first cycle on.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= '0;
      busy_vec_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= cnt_d[r];
      busy_vec_q <= busy_vec_d;
    end
  end

  assign busy_vec = busy_vec_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard. The reference model records, per
// register, the absolute cycle from which a dependent may issue; hazards are
// derived from that with plain integer comparisons.
module tb_reg_scoreboard;

  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NISSUE = 2;
  localparam int NSRC   = 2;
  localparam int LATW   = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NISSUE-1:0]         issue_valid;
  logic [NISSUE-1:0]         issue_wr;
  logic [NISSUE*AW-1:0]      issue_dst;
  logic [NISSUE*LATW-1:0]    issue_lat;
  logic [NISSUE*NSRC*AW-1:0] src_addr;
  logic [NISSUE*NSRC-1:0]    src_busy;
  logic [NISSUE-1:0]         issue_ok;
  logic                      stall;
  logic [NREGS-1:0]          busy_vec;

  reg_scoreboard #(
    .NREGS(NREGS), .AW(AW), .NISSUE(NISSUE), .NSRC(NSRC), .LATW(LATW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src_addr(src_addr), .src_busy(src_busy),
    .issue_ok(issue_ok), .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NISSUE*NSRC-1:0] src_busy;
    logic [NISSUE-1:0]      issue_ok;
    logic                   stall;
    logic [NREGS-1:0]       busy_vec;
  } exp_t;

  exp_t exp_q[$];
  int   ready_at [NREGS];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs on the falling edge against the oldest
  // expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("src_busy", 64'(src_busy), 64'(e.src_busy));
      check("issue_ok", 64'(issue_ok), 64'(e.issue_ok));
      check("stall",    64'(stall),    64'(e.stall));
      check("busy_vec", 64'(busy_vec), 64'(e.busy_vec));
    end
  end

  // One cycle of stimulus: drive, predict, queue the prediction, advance model.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input int d0, input int d1, input int l0, input int l1,
                      input int s00, input int s01, input int s10, input int s11,
                      input logic fl = 1'b0, input logic rs = 1'b0,
                      input bit chk = 1'b1);
    int   dst [2];
    int   lat [2];
    int   src [4];
    exp_t e;
    bit   older_ok;
    bit   b;
    dst = '{d0, d1};
    lat = '{l0, l1};
    src = '{s00, s01, s10, s11};
    @(posedge clk);
    #1;
    reset       = rs;
    flush       = fl;
    issue_valid = v;
    issue_wr    = w;
    issue_dst   = {AW'(d1), AW'(d0)};
    issue_lat   = {LATW'(l1), LATW'(l0)};
    src_addr    = {AW'(s11), AW'(s10), AW'(s01), AW'(s00)};

    e = '0;
    for (int i = 0; i < NISSUE; i++) begin
      for (int j = 0; j < NSRC; j++) begin
        int s;
        s = src[i*NSRC+j];
        b = (s != 0) && (cyc < ready_at[s]);
        for (int k = 0; k < i; k++)
          if (v[k] && w[k] && dst[k] == s && s != 0) b = 1'b1;
        e.src_busy[i*NSRC+j] = b;
      end
    end
    older_ok = 1'b1;
    for (int i = 0; i < NISSUE; i++) begin
      e.issue_ok[i] = v[i] && !fl && !rs && older_ok &&
                      !e.src_busy[i*NSRC] && !e.src_busy[i*NSRC+1];
      older_ok = e.issue_ok[i];
      if (v[i] && !e.issue_ok[i]) e.stall = 1'b1;
    end
    for (int r = 0; r < NREGS; r++)
      e.busy_vec[r] = (cyc < ready_at[r]);
    if (chk) exp_q.push_back(e);

    if (rs || fl) begin
      for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
    end else begin
      for (int i = 0; i < NISSUE; i++) begin
        if (e.issue_ok[i] && w[i] && dst[i] != 0) begin
          int le;
          le = (lat[i] == 0) ? 1 : lat[i];
          if (cyc + le > ready_at[dst[i]]) ready_at[dst[i]] = cyc + le;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = '0; issue_wr = '0;
    issue_dst = '0; issue_lat = '0; src_addr = '0;
    for (int r = 0; r < NREGS; r++) ready_at[r] = 0;

    // Reset: first cycle unchecked (state undefined), second checked.
    step(2'b11, 2'b11, 1, 2, 1, 1, 10, 11, 12, 13, 1'b0, 1'b1, 1'b0);
    step(2'b11, 2'b11, 1, 2, 1, 1, 10, 11, 12, 13, 1'b0, 1'b1);
    // Two independent slots after reset.
    step(2'b11, 2'b11, 1, 2, 1, 1, 10, 11, 12, 13);

    // r5 latency 3, then slot0 reads r5 for three cycles.
    step(2'b01, 2'b01, 5, 0, 3, 0, 0, 0, 0, 0);
    repeat (3) step(2'b01, 2'b00, 0, 0, 0, 0, 5, 0, 0, 0);
    idle();

    // Same-group RAW on r7, then the consumer re-presented as slot0.
    step(2'b11, 2'b01, 7, 0, 1, 0, 0, 0, 7, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0);

    // WAW: r4 lat 7, then r4 lat 2; poll r4 until well after free.
    step(2'b01, 2'b01, 4, 0, 7, 0, 0, 0, 0, 0);
    step(2'b01, 2'b01, 4, 0, 2, 0, 0, 0, 0, 0);
    repeat (8) step(2'b01, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);

    // Slot0 blocked on r9; independent slot1 writing r20 must not load.
    step(2'b01, 2'b01, 9, 0, 5, 0, 0, 0, 0, 0);
    step(2'b11, 2'b11, 0, 20, 0, 7, 9, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0, 20, 0, 0, 0);
    repeat (4) idle();

    // Flush with r3 pending and a valid group in the same cycle.
    step(2'b01, 2'b01, 3, 0, 6, 0, 0, 0, 0, 0);
    step(2'b11, 2'b11, 1, 2, 3, 3, 0, 0, 0, 0, 1'b1);
    step(2'b01, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0);

    // Destination r0 never becomes busy; latency 0 behaves as 1.
    step(2'b01, 2'b01, 0, 0, 7, 0, 0, 0, 0, 0);
    step(2'b01, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0, 6, 0, 0, 0);

    // Randomized traffic over a small register window for frequent hazards.
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom), 2'($urandom),
           int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
           int'($urandom_range(0, 7)),  int'($urandom_range(0, 7)),
           int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
           int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    repeat (2) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
